hamming_serial_link: RTL and testbench
======================================

// Module: hamming_serial_link
// PURPOSE
//   Parametrised Hamming(7,4) serial link: TX + RX in one block, clk/rst_n domain.
//   TX accepts DATA_W-bit word (ready/valid), splits into DATA_W/4 nibbles, encodes each
//   to a 7-bit codeword, sends one framed serial word at CLKS_PER_BIT clocks per bit.
//   RX deframes, decodes, corrects single-bit errors per codeword, presents word + status.
//   Sits at top of the link datapath; LOOPBACK ties TX line to RX internally for bring-up.
// PARAMETERS
//   DATA_W        8  payload width; multiple of 4, 4..32; NUM_CW = DATA_W/4 codewords
//   CLKS_PER_BIT  4  clocks per serial bit; even, >=2
//   LOOPBACK      1  1: RX input = serial_tx internally, serial_rx ignored; 0: RX uses serial_rx
// PORTS
//   clk           in   1       system clock
//   rst_n         in   1       reset, asynchronous, active-low
//   tx_valid      in   1       tx_data valid
//   tx_data       in   DATA_W  payload to send
//   tx_ready      out  1       TX idle, can accept
//   serial_tx     out  1       serial line out, idle high
//   serial_rx     in   1       serial line in (LOOPBACK=0 only)
//   rx_valid      out  1       1-cycle pulse: rx_data/rx_corrected valid
//   rx_data       out  DATA_W  decoded payload; held until next rx_valid
//   rx_corrected  out  1       with rx_valid: >=1 codeword had single-bit correction
//   rx_frame_err  out  1       1-cycle pulse: stop bit sampled 0, frame dropped
//   rx_err_cnt    out  8       corrected-frame count, saturates at 255
// BEHAVIOUR
//   Reset (async, any state): both FSMs IDLE; serial_tx=1, tx_ready=1, rx_valid=0,
//     rx_data=0, rx_corrected=0, rx_frame_err=0, rx_err_cnt=0. Frame in flight is lost.
//   Codeword: positions 1..7 = p1 p2 d0 p4 d1 d2 d3 (d0 = nibble LSB); even parity;
//     p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3. Nibble i = tx_data[4i+3:4i].
//   Frame: start(0), codeword 0..NUM_CW-1 each position 1 first, stop(1);
//     FRAME_BITS = 7*NUM_CW+2; each bit held exactly CLKS_PER_BIT cycles.
//   TX FSM IDLE->START->DATA->STOP->IDLE. Accept when tx_valid&&tx_ready; tx_data
//     registered; tx_ready=0 next cycle; start bit on serial_tx from next cycle. tx_ready
//     returns 1 in the cycle after stop bit ends; tx_valid while busy ignored (not queued).
//   RX FSM IDLE->START->DATA->STOP->IDLE. IDLE: falling edge on line -> START.
//     START: after CLKS_PER_BIT/2 cycles resample; 1 = false start -> IDLE, no outputs.
//     DATA: sample every CLKS_PER_BIT cycles (mid-bit), 7*NUM_CW samples.
//     STOP: mid-bit sample; 1 -> decode, rx_valid next cycle; 0 -> rx_frame_err pulse,
//     rx_data unchanged, no rx_valid.
//   Decode per codeword: syndrome s={s4,s2,s1}; s!=0 -> invert position s, then extract
//     nibble. Double errors are miscorrected silently (no detection).
//   rx_err_cnt += 1 per valid frame with rx_corrected=1 (not per codeword); holds at 255.
//   Latency (LOOPBACK=1): rx_valid <= FRAME_BITS*CLKS_PER_BIT+4 cycles after accept.
//   Back-to-back: line returns to idle >=1 cycle before next start bit; RX rearms in IDLE.
// CONFIGURATION
//   HAMMING_ERR_INJECT_EN defined: extra ports inj_valid(in,1), inj_pos(in,3). If
//     inj_valid=1 at TX accept, codeword 0 position inj_pos (1..7; 0 = none) inverted
//     before serialization. Not defined: ports absent, no corruption path.
// TESTING
//   Reset: rst_n low mid-frame -> serial_tx=1, tx_ready=1, rx_valid=0, rx_err_cnt=0 at once.
//   Clean loopback DATA_W=8,CPB=4: send 0xA5 -> rx_data=0xA5, rx_corrected=0, within 68 cycles.
//   Back-to-back: tx_valid held, 0x3C then 0xC3 -> two rx_valid in order; tx_ready=0 in frames.
//   Inject (HAMMING_ERR_INJECT_EN): 0x5A, inj_pos=5 -> rx_data=0x5A, rx_corrected=1, cnt=1.
//   LOOPBACK=0: serial_rx low 1 cycle -> no rx_valid; frame with stop=0 -> rx_frame_err pulse.
//   Saturation: 300 injected frames -> rx_err_cnt=255, stays 255; rx_data still correct.

Source files
------------

// File: rtl/hamming_serial_link.sv
// hamming_serial_link: Hamming(7,4) framed serial TX+RX with single-bit correction; define HAMMING_ERR_INJECT_EN for codeword-0 error injection ports.
module hamming_serial_link #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int LOOPBACK     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              serial_tx,
    input  logic              serial_rx,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic              inj_valid,
    input  logic [2:0]        inj_pos,
`endif
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_corrected,
    output logic              rx_frame_err,
    output logic [7:0]        rx_err_cnt
);
    localparam int NUM_CW  = DATA_W / 4;
    localparam int CW_BITS = 7 * NUM_CW;
    localparam int CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W   = $clog2(CW_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CW_BITS - 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    // returns {corrected, nibble}; a nonzero syndrome names the flipped position
    function automatic logic [4:0] dec(input logic [6:0] c);
        logic [2:0] s;
        logic [6:0] f;
        s = {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
        f = c;
        if (s != 3'd0) f[s - 3'd1] = ~f[s - 3'd1];
        return {s != 3'd0, f[6], f[5], f[4], f[2]};
    endfunction

    logic [1:0]         tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]   tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [CW_BITS-1:0] tx_code, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [1:0]         rx_sync_q;
    logic               rx_prev_q, rx_line, rx_sample, tx_tick;
    logic               rx_valid_q, rx_valid_d, rx_corr_q, rx_corr_d, rx_ferr_q, rx_ferr_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d, dec_data;
    logic               dec_corr;
    logic [4:0]         dec_cw;
    logic [7:0]         rx_errs_q, rx_errs_d;

    always_comb begin
        tx_code = '0;
        for (int i = 0; i < NUM_CW; i++) tx_code[7*i +: 7] = enc(tx_data[4*i +: 4]);
`ifdef HAMMING_ERR_INJECT_EN
        if (inj_valid && inj_pos != 3'd0) tx_code[inj_pos - 3'd1] = ~tx_code[inj_pos - 3'd1];
`endif
    end

    assign tx_tick   = tx_cnt_q == CNT_BIT;
    assign tx_ready  = tx_state_q == S_IDLE;
    assign serial_tx = (tx_state_q == S_START) ? 1'b0 : (tx_state_q == S_DATA) ? tx_sh_q[0] : 1'b1;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_tick ? CNT_ONE : tx_cnt_q + CNT_ONE;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        if (tx_state_q == S_IDLE) begin
            tx_cnt_d   = CNT_ONE;
            tx_state_d = tx_valid ? S_START : S_IDLE;
            tx_sh_d    = tx_valid ? tx_code : tx_sh_q;
        end else if (tx_tick) begin
            case (tx_state_q)
                S_START: begin
                    tx_state_d = S_DATA;
                    tx_bit_d   = '0;
                end
                S_DATA: begin
                    tx_state_d = (tx_bit_q == BIT_LAST) ? S_STOP : S_DATA;
                    tx_bit_d   = tx_bit_q + BIT_ONE;
                    tx_sh_d    = tx_sh_q >> 1;
                end
                default: tx_state_d = S_IDLE;
            endcase
        end
    end

    assign rx_line   = (LOOPBACK != 0) ? serial_tx : rx_sync_q[1];
    assign rx_sample = rx_cnt_q == ((rx_state_q == S_START) ? CNT_MID : CNT_BIT);

    always_comb begin
        dec_data = '0;
        dec_corr = 1'b0;
        dec_cw   = '0;
        for (int i = 0; i < NUM_CW; i++) begin
            dec_cw             = dec(rx_sh_q[7*i +: 7]);
            dec_data[4*i +: 4] = dec_cw[3:0];
            dec_corr           = dec_corr | dec_cw[4];
        end
    end

    // the edge-detect cycle counts as the first cycle of the start bit
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_sample ? CNT_ONE : rx_cnt_q + CNT_ONE;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        rx_data_d  = rx_data_q;
        rx_corr_d  = rx_corr_q;
        rx_errs_d  = rx_errs_q;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d   = CNT_ONE;
                rx_state_d = (rx_prev_q && !rx_line) ? S_START : S_IDLE;
            end
            S_START: if (rx_sample) begin
                rx_state_d = rx_line ? S_IDLE : S_DATA;
                rx_bit_d   = '0;
            end
            S_DATA: if (rx_sample) begin
                rx_state_d = (rx_bit_q == BIT_LAST) ? S_STOP : S_DATA;
                rx_bit_d   = rx_bit_q + BIT_ONE;
                rx_sh_d    = {rx_line, rx_sh_q[CW_BITS-1:1]};
            end
            default: if (rx_sample) begin
                rx_state_d = S_IDLE;
                rx_valid_d = rx_line;
                rx_ferr_d  = !rx_line;
                rx_data_d  = rx_line ? dec_data : rx_data_q;
                rx_corr_d  = rx_line ? dec_corr : rx_corr_q;
                rx_errs_d  = (rx_line && dec_corr && rx_errs_q != 8'hFF) ? rx_errs_q + 8'd1 : rx_errs_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= CNT_ONE;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= CNT_ONE;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_corr_q  <= 1'b0;
            rx_errs_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_sync_q  <= {rx_sync_q[0], serial_rx};
            rx_prev_q  <= rx_line;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_data_q  <= rx_data_d;
            rx_corr_q  <= rx_corr_d;
            rx_errs_q  <= rx_errs_d;
        end
    end

    assign rx_valid     = rx_valid_q;
    assign rx_data      = rx_data_q;
    assign rx_corrected = rx_corr_q;
    assign rx_frame_err = rx_ferr_q;
    assign rx_err_cnt   = rx_errs_q;
endmodule

// File: tb/tb_hamming_serial_link.sv
// tb_hamming_serial_link: loopback instance driven through TX, external-line instance driven bit by bit.
module tb_hamming_serial_link;
    typedef struct packed {
        logic [7:0] d;
        logic       c;
    } exp_t;
    typedef struct packed {
        logic [7:0]  data;
        logic [13:0] flip;
        logic        stop;
        logic [7:0]  exp_data;
        logic        exp_corr;
    } vec_t;

    logic clk, rst_n;
    logic tx_valid_a, tx_ready_a, serial_tx_a, rx_valid_a, rx_corrected_a, rx_frame_err_a;
    logic [7:0] tx_data_a, rx_data_a, rx_err_cnt_a;
    logic tx_ready_b, serial_tx_b, serial_rx_b, rx_valid_b, rx_corrected_b, rx_frame_err_b;
    logic [7:0] rx_data_b, rx_err_cnt_b;
    logic inj_valid;
    logic [2:0] inj_pos;

    int n_vec = 0, n_bad = 0, ferr_seen = 0, vb_seen = 0, err_b = 0;
    exp_t q_a[$], q_b[$];
    exp_t ea, eb;
    vec_t vt[7];

    hamming_serial_link #(.DATA_W(8), .CLKS_PER_BIT(4), .LOOPBACK(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_a), .tx_data(tx_data_a),
        .tx_ready(tx_ready_a), .serial_tx(serial_tx_a), .serial_rx(1'b1),
`ifdef HAMMING_ERR_INJECT_EN
        .inj_valid(inj_valid), .inj_pos(inj_pos),
`endif
        .rx_valid(rx_valid_a), .rx_data(rx_data_a), .rx_corrected(rx_corrected_a),
        .rx_frame_err(rx_frame_err_a), .rx_err_cnt(rx_err_cnt_a));

    hamming_serial_link #(.DATA_W(8), .CLKS_PER_BIT(4), .LOOPBACK(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_valid(1'b0), .tx_data(8'h00),
        .tx_ready(tx_ready_b), .serial_tx(serial_tx_b), .serial_rx(serial_rx_b),
`ifdef HAMMING_ERR_INJECT_EN
        .inj_valid(1'b0), .inj_pos(3'd0),
`endif
        .rx_valid(rx_valid_b), .rx_data(rx_data_b), .rx_corrected(rx_corrected_b),
        .rx_frame_err(rx_frame_err_b), .rx_err_cnt(rx_err_cnt_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [13:0] enc8(input logic [7:0] d);
        logic [13:0] c;
        logic [3:0]  n;
        c = '0;
        for (int i = 0; i < 2; i++) begin
            n = d[4*i +: 4];
            c[7*i +: 7] = {n[3], n[2], n[1], n[1] ^ n[2] ^ n[3], n[0], n[0] ^ n[2] ^ n[3], n[0] ^ n[1] ^ n[3]};
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid_a) begin
                if (q_a.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL rx_a_unexpected: got rx_valid with data 0x%0h, expected none", rx_data_a);
                end else begin
                    ea = q_a.pop_front();
                    chk("rx_a_data", rx_data_a, ea.d);
                    chk("rx_a_corr", rx_corrected_a, ea.c);
                end
            end
            if (rx_valid_b) begin
                vb_seen++;
                if (q_b.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL rx_b_unexpected: got rx_valid with data 0x%0h, expected none", rx_data_b);
                end else begin
                    eb = q_b.pop_front();
                    chk("rx_b_data", rx_data_b, eb.d);
                    chk("rx_b_corr", rx_corrected_b, eb.c);
                end
            end
            if (rx_frame_err_b) ferr_seen++;
        end
    end

    task automatic send_a(input logic [7:0] d, input logic c);
        int t = 0;
        tx_data_a  = d;
        tx_valid_a = 1'b1;
        while (!tx_ready_a && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send_a_ready_timeout", t >= 200, 0);
        q_a.push_back('{d, c});
        @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] d, input logic [13:0] flip, input logic stop);
        logic [15:0] f;
        f = {stop, enc8(d) ^ flip, 1'b0};
        for (int k = 0; k < 16; k++) begin
            serial_rx_b = f[k];
            repeat (4) @(negedge clk);
        end
        serial_rx_b = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic push_b(input logic [7:0] d, input logic c);
        q_b.push_back('{d, c});
        if (c && err_b < 255) err_b++;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", q_a.size() + q_b.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int vb0;
        logic [7:0] lb[4];
        vt[0] = '{8'hA5, 14'h0000, 1'b1, 8'hA5, 1'b0};
        vt[1] = '{8'hA5, 14'h0004, 1'b1, 8'hA5, 1'b1};
        vt[2] = '{8'h3C, 14'h2000, 1'b1, 8'h3C, 1'b1};
        vt[3] = '{8'hFF, 14'h0401, 1'b1, 8'hFF, 1'b1};
        vt[4] = '{8'h00, 14'h0003, 1'b1, 8'h01, 1'b1};
        vt[5] = '{8'h5A, 14'h0000, 1'b0, 8'h01, 1'b0};
        vt[6] = '{8'h96, 14'h0002, 1'b1, 8'h96, 1'b1};
        lb = '{8'h00, 8'hFF, 8'h69, 8'h81};
        rst_n = 1'b0; tx_valid_a = 1'b0; tx_data_a = 8'h00; serial_rx_b = 1'b1;
        inj_valid = 1'b0; inj_pos = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_serial_tx", serial_tx_a, 1);
        chk("rst_tx_ready", tx_ready_a, 1);
        chk("rst_rx_valid", rx_valid_a, 0);
        chk("rst_rx_data", rx_data_a, 0);
        chk("rst_rx_corr", rx_corrected_a, 0);
        chk("rst_frame_err", rx_frame_err_b, 0);
        chk("rst_err_cnt", rx_err_cnt_b, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            if (vt[i].stop) push_b(vt[i].exp_data, vt[i].exp_corr);
            send_b(vt[i].data, vt[i].flip, vt[i].stop);
            if (!vt[i].stop) begin
                chk("ferr_pulse", ferr_seen, 1);
                chk("ferr_data_held", rx_data_b, vt[i].exp_data);
            end
        end
        wait_drain();
        chk("table_err_cnt", rx_err_cnt_b, err_b);

        vb0 = vb_seen;
        serial_rx_b = 1'b0;
        @(negedge clk);
        serial_rx_b = 1'b1;
        repeat (30) @(negedge clk);
        chk("false_start_no_valid", vb_seen, vb0);
        chk("false_start_no_ferr", ferr_seen, 1);
        push_b(8'hE7, 1'b0);
        send_b(8'hE7, 14'h0000, 1'b1);
        wait_drain();

        send_a(8'hA5, 1'b0);
        tx_valid_a = 1'b0;
        lat = 1;
        while (!rx_valid_a && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat > 68) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles, expected <= 68", lat);
        end
        wait_drain();

        for (int i = 0; i < 4; i++) begin
            send_a(lb[i], 1'b0);
            tx_valid_a = 1'b0;
            wait_drain();
        end

        send_a(8'h3C, 1'b0);
        repeat (10) @(negedge clk);
        chk("b2b_busy_first", tx_ready_a, 0);
        send_a(8'hC3, 1'b0);
        tx_valid_a = 1'b0;
        repeat (10) @(negedge clk);
        chk("b2b_busy_second", tx_ready_a, 0);
        wait_drain();
        repeat (80) @(negedge clk);
        chk("b2b_idle", tx_ready_a, 1);
        chk("a_err_cnt_clean", rx_err_cnt_a, 0);

`ifdef HAMMING_ERR_INJECT_EN
        inj_valid = 1'b1;
        inj_pos   = 3'd5;
        send_a(8'h5A, 1'b1);
        tx_valid_a = 1'b0;
        inj_valid  = 1'b0;
        wait_drain();
        chk("inj_err_cnt", rx_err_cnt_a, 1);
`endif

        send_a(8'h77, 1'b0);
        tx_valid_a = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_serial_tx", serial_tx_a, 1);
        chk("midrst_tx_ready", tx_ready_a, 1);
        chk("midrst_rx_valid", rx_valid_a, 0);
        chk("midrst_err_cnt", rx_err_cnt_b, 0);
        chk("midrst_rx_data_b", rx_data_b, 0);
        q_a.delete();
        q_b.delete();
        err_b = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_a(8'h42, 1'b0);
        tx_valid_a = 1'b0;
        wait_drain();

        for (int i = 0; i < 300; i++) begin
            logic [7:0] d;
            d = 8'(i * 53 + 7);
            push_b(d, 1'b1);
            send_b(d, 14'd1 << $urandom_range(0, 13), 1'b1);
        end
        wait_drain();
        chk("sat_model", rx_err_cnt_b, err_b);
        chk("sat_cnt", rx_err_cnt_b, 8'd255);
        push_b(8'hB4, 1'b1);
        send_b(8'hB4, 14'h0040, 1'b1);
        wait_drain();
        chk("sat_hold", rx_err_cnt_b, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
